aes_round_engine: RTL and testbench
===================================

Name: aes_round_engine

Overview:
Iterative AES-128 encryption datapath in the execute stage, directly downstream of key_expansion. Consumes the 11 round keys it produces and encrypts one 128-bit block per start.
SubBytes runs one byte per cycle through S-box lookups on the unified memory read port, using the same S-box region key_expansion uses. ShiftRows, MixColumns and AddRoundKey complete in one cycle per round.

Parameters:
NR, 10, number of rounds; round_keys has NR+1 entries.
ADDR_W, 12, unified memory address width.
SBOX_BASE, 0, unified memory address of S-box entry 0.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to encrypt plaintext
keys_valid  input  1  round_keys are complete and stable
plaintext  input  128  input block; byte 0 = [127:120], column-major per FIPS-197
round_keys  input  128 x [NR:0]  round keys; index 0 = cipher key
busy  output  1  block in progress
done  output  1  one-cycle pulse; ciphertext valid
ciphertext  output  128  result; held until next done
mem_addr  output  ADDR_W  unified memory read address
mem_req  output  1  high while mem_addr is a live S-box lookup
mem_rdata  input  128  unified memory read data; combinational read, only [7:0] used

Behaviour:
- Reset (async, any state): FSM=IDLE, busy=0, done=0, ciphertext=0, round=0, byte_idx=0, state register=0, mem_req=0.
- States: IDLE, SUB, MIX.
- IDLE:
  - start && keys_valid at an edge: state_reg <= plaintext ^ round_keys[0]; round <= 1; byte_idx <= 0; go to SUB.
  - start with keys_valid=0: ignored, no state change.
- SUB:
  - mem_req=1; mem_addr = SBOX_BASE + state_reg byte[byte_idx], zero-extended, modulo 2^ADDR_W.
  - Each edge: byte[byte_idx] <= mem_rdata[7:0]; byte_idx++.
  - After byte_idx=15, byte_idx wraps to 0 and FSM goes to MIX. Exactly 16 cycles.
- MIX (1 cycle):
  - t = ShiftRows(state_reg); if round!=NR, t = MixColumns(t) over GF(2^8), poly 0x11B.
  - state_reg <= t ^ round_keys[round].
  - round<NR: round++, go to SUB.
  - round==NR: ciphertext <= result, done <= 1, go to IDLE.
- Timing:
  - 17 cycles per round. done is high in the cycle after edge 17*NR counted from the start-accepting edge (170 for NR=10).
  - busy=1 in SUB and MIX, 0 in IDLE.
  - done is high for exactly one cycle, during which busy=0.
- Outside SUB: mem_req=0, mem_addr=SBOX_BASE.
- start while busy: ignored, no queueing.
- start in the done cycle: accepted (back-to-back).
- round_keys are read live in MIX. The caller holds them and keys_valid stable while busy; keys_valid falling mid-block is not checked and the result is undefined.
- Reset mid-block: abort, no done pulse, ciphertext=0.

Optional Feature:
AES_BLK_CNT_EN:
- Defined: adds output blk_count (32 bits). Reset to 0; increments on every done pulse; wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- FIPS-197 App. B: round keys from the model for key 2b7e151628aed2a6abf7158809cf4f3c; plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32. done exactly 170 cycles after start; first SUB mem_addr = SBOX_BASE+0x19.
- FIPS-197 App. C.1: key 000102...0f, plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Issue start in its done cycle with App. B inputs -> second done 170 cycles later with the App. B result.
- Pulse start at cycle 50 of a running block -> ignored: one done only, result unchanged. start with keys_valid=0 -> busy stays 0, no mem_req.
- Assert rst_n=0 at cycle 80 of a block -> busy=0, done=0, ciphertext=0 immediately. A new start after release gives the correct App. B result.
- mem_req high for exactly 160 cycles per block. mem_addr stays in [SBOX_BASE, SBOX_BASE+255] whenever mem_req=1.
- With AES_BLK_CNT_EN: 3 blocks -> blk_count=3. Force the counter to 0xFFFFFFFF -> next done gives 0.

Source files
------------

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption: one S-box lookup per cycle, then one ShiftRows/MixColumns/AddRoundKey cycle per round.
// Optional block counter output o_blk_count is enabled by defining AES_BLK_CNT_EN.
module aes_round_engine #(
  parameter int unsigned NR        = 10,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned SBOX_BASE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_keys_valid,
  input  logic [127:0]         i_plaintext,
  input  logic [NR:0][127:0]   i_round_keys,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [127:0]         o_ciphertext,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic                 o_mem_req,
`ifdef AES_BLK_CNT_EN
  output logic [31:0]          o_blk_count,
`endif
  input  logic [127:0]         i_mem_rdata
);

  localparam int unsigned RW = $clog2(NR + 1);

  typedef enum logic [1:0] {StIdle, StSub, StMix} state_e;

  state_e          r_state, w_state_nxt;
  logic [127:0]    r_data, w_data_nxt;
  logic [RW-1:0]   r_round, w_round_nxt;
  logic [3:0]      r_byte_idx, w_byte_nxt;
  logic            r_done, w_done_nxt;
  logic [127:0]    r_ct, w_ct_nxt;
  logic            w_mem_req;
  logic [6:0]      w_lsb;
  logic [7:0]      w_cur_byte;
  logic [127:0]    w_sr, w_mc, w_res;
  logic            w_last;
  logic            w_unused;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k sits at [127-8k -: 8]; bytes are column-major, so row r of column c is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  assign w_lsb      = {~r_byte_idx, 3'b000};
  assign w_cur_byte = r_data[w_lsb +: 8];
  assign w_last     = (r_round == RW'(NR));
  assign w_sr       = shift_rows(r_data);
  assign w_mc       = w_last ? w_sr : mix_columns(w_sr);
  assign w_res      = w_mc ^ i_round_keys[r_round];
  assign w_unused   = ^i_mem_rdata[127:8];

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_round_nxt = r_round;
    w_byte_nxt  = r_byte_idx;
    w_done_nxt  = 1'b0;
    w_ct_nxt    = r_ct;
    w_mem_req   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start && i_keys_valid) begin
          w_data_nxt  = i_plaintext ^ i_round_keys[0];
          w_round_nxt = RW'(1);
          w_byte_nxt  = '0;
          w_state_nxt = StSub;
        end
      end
      StSub: begin
        w_mem_req              = 1'b1;
        w_data_nxt[w_lsb +: 8] = i_mem_rdata[7:0];
        w_byte_nxt             = r_byte_idx + 4'd1;
        if (r_byte_idx == 4'd15) w_state_nxt = StMix;
      end
      StMix: begin
        w_data_nxt = w_res;
        if (w_last) begin
          w_ct_nxt    = w_res;
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_round_nxt = r_round + RW'(1);
          w_state_nxt = StSub;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_data     <= '0;
      r_round    <= '0;
      r_byte_idx <= '0;
      r_done     <= 1'b0;
      r_ct       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_round    <= w_round_nxt;
      r_byte_idx <= w_byte_nxt;
      r_done     <= w_done_nxt;
      r_ct       <= w_ct_nxt;
    end
  end

`ifdef AES_BLK_CNT_EN
  logic [31:0] r_blk_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blk_count <= '0;
    end else if (w_done_nxt) begin
      r_blk_count <= r_blk_count + 32'd1;
    end
  end

  assign o_blk_count = r_blk_count;
`endif

  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;
  assign o_ciphertext = r_ct;
  assign o_mem_req    = w_mem_req;
  // Address defaults to SBOX_BASE whenever no lookup is live.
  assign o_mem_addr   = ADDR_W'(SBOX_BASE) + (w_mem_req ? ADDR_W'(w_cur_byte) : ADDR_W'(0));

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine using FIPS-197 vectors and a behavioural S-box memory.
// Defining AES_BLK_CNT_EN also exercises the block counter.
module tb_aes_round_engine;

  localparam int NR        = 10;
  localparam int ADDR_W    = 12;
  localparam int SBOX_BASE = 0;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 keys_valid = 1'b0;
  logic [127:0]         plaintext = '0;
  logic [NR:0][127:0]   round_keys = '0;
  logic                 busy, done, mem_req;
  logic [127:0]         ciphertext, mem_rdata;
  logic [ADDR_W-1:0]    mem_addr;
`ifdef AES_BLK_CNT_EN
  logic [31:0]          blk_count;
`endif

  logic [7:0]           sbox [256];
  logic [NR:0][127:0]   rk_b, rk_c;
  int                   errors = 0;
  int                   checks = 0;

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_engine #(.NR(NR), .ADDR_W(ADDR_W), .SBOX_BASE(SBOX_BASE)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_keys_valid (keys_valid),
    .i_plaintext  (plaintext),
    .i_round_keys (round_keys),
    .o_busy       (busy),
    .o_done       (done),
    .o_ciphertext (ciphertext),
    .o_mem_addr   (mem_addr),
    .o_mem_req    (mem_req),
`ifdef AES_BLK_CNT_EN
    .o_blk_count  (blk_count),
`endif
    .i_mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {120'd0, sbox[8'(mem_addr - ADDR_W'(SBOX_BASE))]};

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox_of(input logic [7:0] x);
    logic [7:0] sq, p, b;
    sq = x;
    p  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      p  = gmul(p, sq);
    end
    b = p;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [NR:0][127:0] expand_key(input logic [127:0] key);
    logic [31:0]        w [4*(NR+1)];
    logic [31:0]        t;
    logic [7:0]         rcon;
    logic [NR:0][127:0] rk;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  // Called #1 after an edge; returns #1 after the edge that accepts start.
  task automatic launch(input logic [127:0] pt, input logic [NR:0][127:0] rk);
    plaintext  = pt;
    round_keys = rk;
    keys_valid = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int nreq, output bit addr_ok,
                           output logic [ADDR_W-1:0] first_addr);
    cyc        = 0;
    nreq       = (mem_req === 1'b1) ? 1 : 0;
    addr_ok    = 1'b1;
    first_addr = mem_addr;
    while (done !== 1'b1 && cyc < 400) begin
      if (mem_req === 1'b1 && (int'(mem_addr) < SBOX_BASE || int'(mem_addr) > SBOX_BASE + 255))
        addr_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (mem_req === 1'b1) nreq++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ciphertext !== '0) begin errors++; $display("FAIL reset_ct got=%h exp=0", ciphertext); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++;
    if (mem_addr !== ADDR_W'(SBOX_BASE)) begin
      errors++; $display("FAIL reset_mem_addr got=%h exp=%h", mem_addr, ADDR_W'(SBOX_BASE));
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_b;
    int cyc, nreq; bit ok; logic [ADDR_W-1:0] fa;
    launch(PtB, rk_b);
    wait_done(cyc, nreq, ok, fa);
    checks++; if (cyc !== 170) begin errors++; $display("FAIL b_latency got=%0d exp=170", cyc); end
    checks++; if (ciphertext !== CtB) begin errors++; $display("FAIL b_ct got=%h exp=%h", ciphertext, CtB); end
    checks++;
    if (fa !== ADDR_W'(SBOX_BASE + 'h19)) begin
      errors++; $display("FAIL b_first_addr got=%h exp=%h", fa, ADDR_W'(SBOX_BASE + 'h19));
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b_busy_in_done got=%b exp=0", busy); end
    checks++; if (nreq !== 160) begin errors++; $display("FAIL b_mem_req_cycles got=%0d exp=160", nreq); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b_addr_range got=%b exp=1", ok); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b_done_pulse got=%b exp=0", done); end
    checks++; if (ciphertext !== CtB) begin errors++; $display("FAIL b_ct_held got=%h exp=%h", ciphertext, CtB); end
  endtask

  task automatic test_back_to_back;
    int cyc, nreq; bit ok; logic [ADDR_W-1:0] fa;
    launch(PtC, rk_c);
    wait_done(cyc, nreq, ok, fa);
    checks++; if (ciphertext !== CtC) begin errors++; $display("FAIL c_ct got=%h exp=%h", ciphertext, CtC); end
    checks++; if (cyc !== 170) begin errors++; $display("FAIL c_latency got=%0d exp=170", cyc); end
    launch(PtB, rk_b);
    wait_done(cyc, nreq, ok, fa);
    checks++; if (cyc !== 170) begin errors++; $display("FAIL b2b_latency got=%0d exp=170", cyc); end
    checks++; if (ciphertext !== CtB) begin errors++; $display("FAIL b2b_ct got=%h exp=%h", ciphertext, CtB); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy;
    int cyc, nreq, extra; bit ok; logic [ADDR_W-1:0] fa;
    launch(PtB, rk_b);
    repeat (49) begin @(posedge clk); #1; end
    plaintext = PtC;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, nreq, ok, fa);
    checks++; if (cyc !== 120) begin errors++; $display("FAIL busy_start_latency got=%0d exp=120", cyc); end
    checks++; if (ciphertext !== CtB) begin errors++; $display("FAIL busy_start_ct got=%h exp=%h", ciphertext, CtB); end
    extra = 0;
    repeat (200) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_queued got=%0d exp=0", extra); end
  endtask

  task automatic test_keys_invalid;
    int bad;
    bad        = 0;
    plaintext  = PtB;
    keys_valid = 1'b0;
    start      = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (busy !== 1'b0 || mem_req !== 1'b0) bad++; end
    start      = 1'b0;
    keys_valid = 1'b1;
    checks++; if (bad !== 0) begin errors++; $display("FAIL keys_invalid_start got=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid;
    int cyc, nreq; bit ok; logic [ADDR_W-1:0] fa;
    launch(PtB, rk_b);
    repeat (79) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got=%b exp=0", done); end
    checks++; if (ciphertext !== '0) begin errors++; $display("FAIL mid_reset_ct got=%h exp=0", ciphertext); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    launch(PtB, rk_b);
    wait_done(cyc, nreq, ok, fa);
    checks++; if (cyc !== 170) begin errors++; $display("FAIL after_reset_latency got=%0d exp=170", cyc); end
    checks++; if (ciphertext !== CtB) begin errors++; $display("FAIL after_reset_ct got=%h exp=%h", ciphertext, CtB); end
    @(posedge clk); #1;
  endtask

`ifdef AES_BLK_CNT_EN
  task automatic test_blk_count;
    int cyc, nreq; bit ok; logic [ADDR_W-1:0] fa;
    rst_n = 1'b0;
    #3;
    checks++; if (blk_count !== 32'd0) begin errors++; $display("FAIL cnt_reset got=%h exp=0", blk_count); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin launch(PtC, rk_c); wait_done(cyc, nreq, ok, fa); end
    checks++; if (blk_count !== 32'd3) begin errors++; $display("FAIL cnt_three got=%h exp=3", blk_count); end
    force dut.r_blk_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.r_blk_count;
    launch(PtC, rk_c);
    wait_done(cyc, nreq, ok, fa);
    checks++; if (blk_count !== 32'd0) begin errors++; $display("FAIL cnt_wrap got=%h exp=0", blk_count); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) sbox[i] = sbox_of(8'(i));
    rk_b = expand_key(KeyB);
    rk_c = expand_key(KeyC);
    test_reset();
    test_fips_b();
    test_back_to_back();
    test_start_while_busy();
    test_keys_invalid();
    test_reset_mid();
`ifdef AES_BLK_CNT_EN
    test_blk_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
